epb_slave_ctrl: RTL and testbench
=================================

# epb_slave_ctrl

Sequences EPB transactions from the PowerPC external peripheral bus into a simple request/acknowledge register bus shared by up to eight slave cores. It sits directly behind the EPB pad infrastructure. On the pad side it consumes the de-buffered strobes, address and input data, and drives output data, data output-enable and ready/ready-enable. It decodes the slave window, issues a single-cycle request, waits for the slave's acknowledge and handshakes ready back to the processor.

## Interface
- NUM_SLAVES, 4: number of slave ports; power of two, 2..8.
- TIMEOUT_CYCLES, 255: wait-state limit, used only with the timeout feature; range 1..65535.
- epb_clk  input  1  system clock; all logic on rising edge.
- epb_rst  input  1  reset, synchronous, active-high.
- epb_cs_n  input  1  chip select from pads; asynchronous to epb_clk.
- epb_oe_n  input  1  processor output enable; ignored except as qualifier documented below.
- epb_r_w_n  input  1  1 = read, 0 = write.
- epb_be_n  input  2  byte enables, active-low.
- epb_addr  input  23  word address.
- epb_data_in_i  input  16  write data from pads.
- epb_data_out_o  output  16  read data to pads.
- epb_data_oe_n_o  output  1  pad data output-enable, active-low.
- epb_rdy_o  output  1  ready to processor.
- epb_rdy_oe_o  output  1  ready output-enable.
- sl_req_o  output  NUM_SLAVES  one-hot, single-cycle request strobe.
- sl_rnw_o  output  1  latched r_w_n.
- sl_addr_o  output  23  latched address.
- sl_be_o  output  2  latched byte enables, active-high.
- sl_wdata_o  output  16  latched write data.
- sl_rdata_i  input  16*NUM_SLAVES  read data; slave i occupies bits [16i+15:16i].
- sl_ack_i  input  NUM_SLAVES  acknowledge, one cycle per request.
- err_o  output  1  sticky timeout flag.

## Operation
- epb_cs_n passes through a 2-flop synchronizer. Other pad inputs are stable while cs_n is low and are sampled unsynchronized at latch time.
- Slave index = epb_addr[22 -: log2(NUM_SLAVES)].
- FSM states: IDLE, REQ, WAIT, DONE, RELEASE.
- IDLE: on synced cs_n = 0, latch addr, r_w_n, inverted be_n, data_in and the index, then go to REQ.
- REQ: sl_req_o[index] = 1 for exactly one cycle, then go to WAIT.
- WAIT: only sl_ack_i[index] is honoured; acks on other bits are ignored. On ack, capture sl_rdata_i[index] if read, then go to DONE. If synced cs_n has returned high (processor abort), go to RELEASE instead.
- DONE: epb_rdy_o = 1, epb_rdy_oe_o = 1. For reads, epb_data_oe_n_o = 0 and epb_data_out_o = captured data. Hold until synced cs_n = 1, then go to RELEASE.
- RELEASE: one cycle with rdy_o = 0, rdy_oe_o = 1, data_oe_n_o = 1, then go to IDLE. This actively drives ready low before tristating it.
- No new transaction is accepted before returning to IDLE. A cs_n still low on IDLE re-entry is not a new transaction; IDLE waits for synced cs_n = 1 first.
- Reset mid-transaction: next edge forces IDLE, all outputs to reset values, no ack expected. Stale acks after reset are ignored.

## Timing
- Reset values: epb_data_out_o = 0, epb_data_oe_n_o = 1, epb_rdy_o = 0, epb_rdy_oe_o = 0, sl_req_o = 0, sl_rnw_o = 1, sl_addr_o = 0, sl_be_o = 0, sl_wdata_o = 0, err_o = 0.
- cs_n falling edge -> sl_req_o high on the 4th rising edge (2 sync + latch + REQ).
- Earliest ack is the cycle after the request. Ack in cycle k -> rdy_o high from k+1.
- Synced cs_n high -> rdy_o low on the next edge (RELEASE); rdy_oe_o low one edge later.
- Back-to-back transactions: minimum 2 cycles of synced cs_n high between transactions.

## Configuration
- EPB_SLAVE_CTRL_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT.
  - At TIMEOUT_CYCLES without ack: read data = 16'hDEAD, err_o set (sticky until reset), go to DONE, or to RELEASE if aborted.
  - A late ack after timeout is ignored.
- Undefined: WAIT has no bound, the counter is absent, and err_o is tied 0.

## Structure
- Package epb_ctrl_pkg: FSM state enum, TIMEOUT_DATA = 16'hDEAD, index-width function.
- Sub-module epb_sync2: 2-flop synchronizer, reset value 1, used for cs_n.

## Test plan
- Write of 0x1234 to addr 0x600010 (slave 3), ack after 5 cycles -> sl_req_o = 4'b1000 for one cycle, sl_wdata_o = 0x1234, sl_be_o = 2'b11, rdy_o high on cycle after ack, data_oe_n_o stays 1.
- Read from slave 1 returning 0xBEEF with ack 1 cycle after req -> epb_data_out_o = 0xBEEF, data_oe_n_o = 0 in DONE, RELEASE lasts exactly one cycle.
- Ack pulsed on slave 0 while slave 2 is addressed, real ack 3 cycles later -> stray ignored, rdy_o follows the slave 2 ack only.
- Timeout on: TIMEOUT_CYCLES = 16, no ack -> read returns 0xDEAD, err_o = 1 persisting across later good transactions until epb_rst.
- cs_n raised during WAIT, ack 4 cycles later -> no rdy_o pulse, returns to IDLE, next transaction works normally.
- epb_rst asserted for one cycle in DONE -> all outputs at reset values on next edge, FSM in IDLE.

Source files
------------

// File: rtl/epb_ctrl_pkg.sv
// Shared types and helpers for the EPB slave controller.
package epb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        RELEASE
    } epb_state_t;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 4; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/epb_sync2.sv
// Two-flop synchronizer for the pad chip-select; resets to the idle level.
module epb_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/epb_slave_ctrl.sv
// EPB to request/acknowledge slave bus sequencer.
// Optional wait-state timeout: EPB_SLAVE_CTRL_TIMEOUT_EN.
module epb_slave_ctrl
    import epb_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     epb_clk,
    input  logic                     epb_rst,
    input  logic                     epb_cs_n,
    input  logic                     epb_oe_n,
    input  logic                     epb_r_w_n,
    input  logic [1:0]               epb_be_n,
    input  logic [22:0]              epb_addr,
    input  logic [15:0]              epb_data_in_i,
    output logic [15:0]              epb_data_out_o,
    output logic                     epb_data_oe_n_o,
    output logic                     epb_rdy_o,
    output logic                     epb_rdy_oe_o,
    output logic [NUM_SLAVES-1:0]    sl_req_o,
    output logic                     sl_rnw_o,
    output logic [22:0]              sl_addr_o,
    output logic [1:0]               sl_be_o,
    output logic [15:0]              sl_wdata_o,
    input  logic [16*NUM_SLAVES-1:0] sl_rdata_i,
    input  logic [NUM_SLAVES-1:0]    sl_ack_i,
    output logic                     err_o
);

    localparam int IW = idx_width(NUM_SLAVES);

    epb_state_t      state_q;
    epb_state_t      state_d;
    logic            cs_sync;
    logic            armed_q;
    logic [IW-1:0]   idx_q;
    logic            rnw_q;
    logic [22:0]     addr_q;
    logic [1:0]      be_q;
    logic [15:0]     wdata_q;
    logic [15:0]     rdata_q;
    logic            latch;
    logic            cap;
    logic            ack_sel;
    logic            to_hit;
    logic            to_fire;

    wire unused_ok = ^{epb_oe_n, 16'(TIMEOUT_CYCLES)};

    epb_sync2 u_cs_sync (
        .clk (epb_clk),
        .rst (epb_rst),
        .d   (epb_cs_n),
        .q   (cs_sync)
    );

    assign ack_sel = sl_ack_i[idx_q];
    assign to_fire = (state_q == WAIT) && !ack_sel && to_hit;

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cs_sync && armed_q) begin
                    latch   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                // abort wins over a coincident ack
                if (cs_sync) begin
                    state_d = RELEASE;
                end else if (ack_sel) begin
                    cap     = 1'b1;
                    state_d = DONE;
                end else if (to_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cs_sync) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge epb_clk) begin
        if (epb_rst) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            idx_q   <= '0;
            rnw_q   <= 1'b1;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // a held-low cs_n must rise before the next transaction
            if (cs_sync) begin
                armed_q <= 1'b1;
            end else if (latch) begin
                armed_q <= 1'b0;
            end
            if (latch) begin
                idx_q   <= epb_addr[22 -: IW];
                rnw_q   <= epb_r_w_n;
                addr_q  <= epb_addr;
                be_q    <= ~epb_be_n;
                wdata_q <= epb_data_in_i;
            end
            if (cap && rnw_q) begin
                rdata_q <= sl_rdata_i[{idx_q, 4'b0000} +: 16];
            end else if (to_fire) begin
                rdata_q <= TIMEOUT_DATA;
            end
        end
    end

`ifdef EPB_SLAVE_CTRL_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    always_ff @(posedge epb_clk) begin
        if (epb_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + 16'd1;
            end else begin
                cnt_q <= '0;
            end
            if (to_fire) err_q <= 1'b1;
        end
    end

    assign to_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign err_o  = err_q;
`else
    assign to_hit = 1'b0;
    assign err_o  = 1'b0;
`endif

    assign epb_rdy_o       = (state_q == DONE);
    assign epb_rdy_oe_o    = (state_q == DONE) || (state_q == RELEASE);
    assign epb_data_oe_n_o = !((state_q == DONE) && rnw_q);
    assign epb_data_out_o  = ((state_q == DONE) && rnw_q) ? rdata_q : '0;

    assign sl_req_o   = (state_q == REQ) ?
                        ({{(NUM_SLAVES-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign sl_rnw_o   = rnw_q;
    assign sl_addr_o  = addr_q;
    assign sl_be_o    = be_q;
    assign sl_wdata_o = wdata_q;

endmodule

// File: tb/tb_epb_slave_ctrl.sv
// Randomized scoreboard bench for epb_slave_ctrl with slave and memory models.
module tb_epb_slave_ctrl;

    localparam int NS = 4;
    localparam int TO = 16;

    logic          clk;
    logic          epb_rst;
    logic          epb_cs_n;
    logic          epb_oe_n;
    logic          epb_r_w_n;
    logic [1:0]    epb_be_n;
    logic [22:0]   epb_addr;
    logic [15:0]   epb_data_in_i;
    logic [15:0]   epb_data_out_o;
    logic          epb_data_oe_n_o;
    logic          epb_rdy_o;
    logic          epb_rdy_oe_o;
    logic [NS-1:0] sl_req_o;
    logic          sl_rnw_o;
    logic [22:0]   sl_addr_o;
    logic [1:0]    sl_be_o;
    logic [15:0]   sl_wdata_o;
    logic [63:0]   sl_rdata_i;
    logic [NS-1:0] sl_ack_i;
    logic          err_o;

    epb_slave_ctrl #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
        .epb_clk         (clk),
        .epb_rst         (epb_rst),
        .epb_cs_n        (epb_cs_n),
        .epb_oe_n        (epb_oe_n),
        .epb_r_w_n       (epb_r_w_n),
        .epb_be_n        (epb_be_n),
        .epb_addr        (epb_addr),
        .epb_data_in_i   (epb_data_in_i),
        .epb_data_out_o  (epb_data_out_o),
        .epb_data_oe_n_o (epb_data_oe_n_o),
        .epb_rdy_o       (epb_rdy_o),
        .epb_rdy_oe_o    (epb_rdy_oe_o),
        .sl_req_o        (sl_req_o),
        .sl_rnw_o        (sl_rnw_o),
        .sl_addr_o       (sl_addr_o),
        .sl_be_o         (sl_be_o),
        .sl_wdata_o      (sl_wdata_o),
        .sl_rdata_i      (sl_rdata_i),
        .sl_ack_i        (sl_ack_i),
        .err_o           (err_o)
    );

    typedef struct {
        int          idx;
        bit          rnw;
        logic [22:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          cyc;
    } req_exp_t;

    typedef struct {
        bit          rnw;
        logic [15:0] rdata;
        bit          err;
        bit          to;
    } rdy_exp_t;

    typedef struct {
        int delay;
        int stray;
        bit noack;
    } slv_cfg_t;

    req_exp_t    req_q[$];
    rdy_exp_t    rdy_q[$];
    slv_cfg_t    cfg_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] slv_mem[int];

    int checks;
    int errors;
    int cyc;
    int ack_cyc;
    int last_req_cyc;
    int req_seen;
    int rdy_seen;
    bit sticky_err;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] d,
                                          logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] ref_rd(int k);
        return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
    endfunction

    function automatic logic [15:0] slv_rd(int k);
        return slv_mem.exists(k) ? slv_mem[k] : 16'h0000;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // slave model: own memory, configurable latency and stray acks
    initial begin
        slv_cfg_t    sc;
        int          si;
        int          key;
        bit          srnw;
        logic [1:0]  sbe;
        logic [15:0] swd;
        sl_ack_i   = '0;
        sl_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (sl_req_o != '0) begin
                if (cfg_q.size() == 0) begin
                    chk("cfg_missing", 1, 0);
                end else begin
                    sc = cfg_q.pop_front();
                    si = 0;
                    for (int j = 0; j < NS; j++) if (sl_req_o[j]) si = j;
                    key  = int'(sl_addr_o);
                    srnw = sl_rnw_o;
                    sbe  = sl_be_o;
                    swd  = sl_wdata_o;
                    if (!sc.noack) begin
                        for (int k = 1; k <= sc.delay; k++) begin
                            @(negedge clk);
                            sl_ack_i = '0;
                            if (k == 1 && sc.stray >= 0) sl_ack_i[sc.stray] = 1'b1;
                            if (k == sc.delay) begin
                                sl_rdata_i = {$urandom, $urandom};
                                sl_rdata_i[si*16 +: 16] = slv_rd(key);
                                sl_ack_i[si] = 1'b1;
                                ack_cyc = cyc;
                                if (!srnw) slv_mem[key] = merge(slv_rd(key), swd, sbe);
                            end
                        end
                        @(negedge clk);
                        sl_ack_i = '0;
                    end
                end
            end
        end
    end

    // monitor: pops expectations when the DUT presents req or rdy
    initial begin
        req_exp_t re;
        rdy_exp_t ye;
        bit       prev_req;
        bit       prev_rdy;
        int       rel_cnt;
        prev_req = 0;
        prev_rdy = 0;
        rel_cnt  = 0;
        forever begin
            @(negedge clk);
            if (sl_req_o != '0) begin
                if (prev_req) begin
                    chk("req_one_cycle", 1, 0);
                end else if (req_q.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    re = req_q.pop_front();
                    chk("req_onehot", 32'(sl_req_o), 32'd1 << re.idx);
                    chk("req_rnw", 32'(sl_rnw_o), 32'(re.rnw));
                    chk("req_addr", 32'(sl_addr_o), 32'(re.addr));
                    chk("req_be", 32'(sl_be_o), 32'(re.be));
                    if (!re.rnw) chk("req_wdata", 32'(sl_wdata_o), 32'(re.wdata));
                    chk("req_latency", cyc, re.cyc);
                    last_req_cyc = cyc;
                    req_seen++;
                end
            end
            prev_req = (sl_req_o != '0);
            if (epb_rdy_o && !prev_rdy) begin
                if (rdy_q.size() == 0) begin
                    chk("rdy_unexpected", 1, 0);
                end else begin
                    ye = rdy_q.pop_front();
                    chk("rdy_oe", 32'(epb_rdy_oe_o), 1);
                    chk("data_oe_n", 32'(epb_data_oe_n_o), 32'(!ye.rnw));
                    if (ye.rnw) chk("rdata", 32'(epb_data_out_o), 32'(ye.rdata));
                    chk("err", 32'(err_o), 32'(ye.err));
                    if (ye.to) chk("rdy_timeout_cyc", cyc, last_req_cyc + TO + 1);
                    else chk("rdy_after_ack", cyc, ack_cyc + 1);
                    rdy_seen++;
                end
            end
            prev_rdy = epb_rdy_o;
            if (!epb_data_oe_n_o) chk("data_oe_only_rdy", 32'(epb_rdy_o), 1);
            if (epb_rdy_oe_o && !epb_rdy_o) begin
                rel_cnt++;
            end else begin
                if (rel_cnt != 0) chk("release_len", rel_cnt, 1);
                rel_cnt = 0;
            end
        end
    end

    task automatic check_rst_vals();
        chk("rst_data_out", 32'(epb_data_out_o), 0);
        chk("rst_data_oe_n", 32'(epb_data_oe_n_o), 1);
        chk("rst_rdy", 32'(epb_rdy_o), 0);
        chk("rst_rdy_oe", 32'(epb_rdy_oe_o), 0);
        chk("rst_req", 32'(sl_req_o), 0);
        chk("rst_rnw", 32'(sl_rnw_o), 1);
        chk("rst_addr", 32'(sl_addr_o), 0);
        chk("rst_be", 32'(sl_be_o), 0);
        chk("rst_wdata", 32'(sl_wdata_o), 0);
        chk("rst_err", 32'(err_o), 0);
    endtask

    task automatic do_txn(input int idx, input bit rnw, input logic [20:0] lo,
                          input logic [1:0] be_n, input logic [15:0] wd,
                          input int delay, input int stray, input bit noack,
                          input bit abort, input bit rst_done);
        logic [22:0] a;
        req_exp_t    re;
        rdy_exp_t    ye;
        slv_cfg_t    sc;
        int          q0;
        int          r0;
        bit          got;
        a = {2'(idx), lo};
        sc.delay = delay;
        sc.stray = stray;
        sc.noack = noack;
        cfg_q.push_back(sc);
        if (!abort) begin
            ye.rnw = rnw;
            ye.to  = noack;
            if (noack) begin
                ye.rdata   = 16'hDEAD;
                sticky_err = 1'b1;
            end else begin
                ye.rdata = ref_rd(int'(a));
            end
            ye.err = sticky_err;
            rdy_q.push_back(ye);
            if (!rnw && !noack) ref_mem[int'(a)] = merge(ref_rd(int'(a)), wd, ~be_n);
        end
        @(negedge clk);
        re.idx   = idx;
        re.rnw   = rnw;
        re.addr  = a;
        re.be    = ~be_n;
        re.wdata = wd;
        re.cyc   = cyc + 3;
        req_q.push_back(re);
        q0 = req_seen;
        r0 = rdy_seen;
        epb_addr      = a;
        epb_r_w_n     = rnw;
        epb_be_n      = be_n;
        epb_data_in_i = wd;
        epb_cs_n      = 1'b0;
        got = 0;
        if (abort) begin
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                got = (req_seen != q0);
            end
            if (!got) chk("req_wait_expired", 1, 0);
            @(negedge clk);
            epb_cs_n = 1'b1;
            repeat (12) @(negedge clk);
        end else begin
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                got = (rdy_seen != r0);
            end
            if (!got) chk("rdy_wait_expired", 1, 0);
            if (rst_done) begin
                epb_rst  = 1'b1;
                epb_cs_n = 1'b1;
                @(negedge clk);
                check_rst_vals();
                epb_rst    = 1'b0;
                sticky_err = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                epb_cs_n = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
    endtask

    initial begin
        int          ri;
        bit          rr;
        int          rd;
        int          rs;
        checks        = 0;
        errors        = 0;
        req_seen      = 0;
        rdy_seen      = 0;
        ack_cyc       = 0;
        last_req_cyc  = 0;
        sticky_err    = 0;
        epb_rst       = 1'b1;
        epb_cs_n      = 1'b1;
        epb_oe_n      = 1'b1;
        epb_r_w_n     = 1'b1;
        epb_be_n      = 2'b11;
        epb_addr      = '0;
        epb_data_in_i = '0;
        repeat (3) @(negedge clk);
        epb_rst = 1'b0;
        @(negedge clk);
        check_rst_vals();
        repeat (2) @(negedge clk);

        do_txn(3, 0, 21'h000010, 2'b00, 16'h1234, 5, -1, 0, 0, 0);
        do_txn(1, 0, 21'h000010, 2'b00, 16'hBEEF, 2, -1, 0, 0, 0);
        do_txn(1, 1, 21'h000010, 2'b00, 16'h0000, 1, -1, 0, 0, 0);
        do_txn(2, 0, 21'h000004, 2'b01, 16'hA5C3, 2, -1, 0, 0, 0);
        do_txn(2, 1, 21'h000004, 2'b00, 16'h0000, 4, 0, 0, 0, 0);
        do_txn(3, 1, 21'h000010, 2'b00, 16'h0000, 6, -1, 0, 1, 0);
        do_txn(3, 1, 21'h000010, 2'b10, 16'h0000, 2, -1, 0, 0, 0);

`ifdef EPB_SLAVE_CTRL_TIMEOUT_EN
        do_txn(0, 1, 21'h000002, 2'b00, 16'h0000, 1, -1, 1, 0, 0);
        do_txn(3, 1, 21'h000010, 2'b00, 16'h0000, 3, -1, 0, 0, 0);
        do_txn(0, 0, 21'h000002, 2'b00, 16'h7777, 1, -1, 0, 0, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            ri = $urandom_range(0, 3);
            rr = 1'($urandom_range(0, 1));
            rd = $urandom_range(1, 6);
            rs = (rd >= 3 && $urandom_range(0, 1) == 1) ? (ri + 1) % NS : -1;
            do_txn(ri, rr, 21'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   16'($urandom), rd, rs, 0, 0, 0);
        end

        do_txn(1, 1, 21'h000010, 2'b00, 16'h0000, 2, -1, 0, 0, 1);
        do_txn(2, 1, 21'h000004, 2'b00, 16'h0000, 3, -1, 0, 0, 0);

        repeat (5) @(negedge clk);
        chk("req_q_empty", req_q.size(), 0);
        chk("rdy_q_empty", rdy_q.size(), 0);
        chk("cfg_q_empty", cfg_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
